// File: rtl/ucie_ctl_tx_buffer_pkg.sv
// Shared definitions for the UCIe controller TX elastic buffer.
// Build-time defaults: `NBYTES (bytes per beat) and `TX_DEPTH (FIFO entries),
// both overridable from the command line. The optional statistics counters
// are enabled with the UCIE_CTL_TX_STATS_EN macro.
`ifndef NBYTES
`define NBYTES 8
`endif
`ifndef TX_DEPTH
`define TX_DEPTH 4
`endif

package ucie_ctl_tx_buffer_pkg;

  localparam int NBYTES_DEF   = `NBYTES;
  localparam int TX_DEPTH_DEF = `TX_DEPTH;

  // Width of the saturating statistics counters.
  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_RUN   = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ucie_ctl_tx_buffer_if.sv
// FDI-side and RDI-side transmit streams of the TX buffer.
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and trdy are both high. The source holds data stable while
// valid is high and trdy is low; trdy never depends combinationally on valid.
//   fdi_*: protocol layer (source) -> buffer (sink)
//   rdi_*: buffer (source) -> physical layer (sink)
interface ucie_ctl_tx_buffer_if
  import ucie_ctl_tx_buffer_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) ();

  logic [NBYTES*8-1:0] fdi_lp_data;
  logic                fdi_lp_valid;
  logic                fdi_pl_trdy;
  logic [NBYTES*8-1:0] rdi_lp_data;
  logic                rdi_lp_valid;
  logic                rdi_pl_trdy;

  // The buffer's view.
  modport slave (
    input  fdi_lp_data, fdi_lp_valid, rdi_pl_trdy,
    output fdi_pl_trdy, rdi_lp_data, rdi_lp_valid
  );

  // The surrounding layers' view (protocol source plus physical sink).
  modport master (
    output fdi_lp_data, fdi_lp_valid, rdi_pl_trdy,
    input  fdi_pl_trdy, rdi_lp_data, rdi_lp_valid
  );

endinterface

// File: rtl/ucie_ctl_tx_out_stage.sv
// Registered output stage of the TX buffer: holds one beat for the physical
// layer and keeps it stable until it is accepted. The parent decides when a
// new beat may be loaded (only when the register is empty or being drained).
module ucie_ctl_tx_out_stage #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_pl_trdy,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  // Load takes priority over release; data only changes on a load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_load_data;
      o_valid <= 1'b1;
    end else if (o_valid && i_pl_trdy) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ucie_ctl_tx_buffer.sv
// UCIe controller TX elastic buffer: circular FIFO between the FDI transmit
// stream and the RDI transmit interface, followed by a registered output
// stage. DEPTH must be a power of two and at least 2; pointers wrap
// naturally. Optional statistics (beat and stall counters) are built when
// UCIE_CTL_TX_STATS_EN is defined.
module ucie_ctl_tx_buffer
  import ucie_ctl_tx_buffer_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int DEPTH  = TX_DEPTH_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_buffer_en,
  ucie_ctl_tx_buffer_if.slave       bus,
  output logic                      o_overflow_detected,
  output logic                      o_busy,
  output tx_state_e                 o_dbg_state
`ifdef UCIE_CTL_TX_STATS_EN
  ,
  output logic [STATS_W-1:0]        o_tx_beat_count,
  output logic [STATS_W-1:0]        o_tx_stall_count
`endif
);

  localparam int W  = NBYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  tx_state_e     r_state;
  tx_state_e     s_next;

  logic          s_trdy;
  logic          s_push;
  logic          s_load;
  logic          s_out_valid;
  logic [W-1:0]  s_out_data;

  assign s_push = bus.fdi_lp_valid && s_trdy;
  assign s_load = (!s_out_valid || bus.rdi_pl_trdy) && (r_count != '0) &&
                  (r_state != TX_IDLE);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= TX_IDLE;
    else       r_state <= s_next;
  end

  // Next-state logic: DRAIN empties FIFO and output register before IDLE.
  always_comb begin
    s_next = r_state;
    case (r_state)
      TX_IDLE:  if (i_buffer_en) s_next = TX_RUN;
      TX_RUN:   if (!i_buffer_en)
                  s_next = ((r_count != '0) || s_out_valid) ? TX_DRAIN : TX_IDLE;
      TX_DRAIN: if (i_buffer_en)
                  s_next = TX_RUN;
                else if ((r_count == '0) && (!s_out_valid || bus.rdi_pl_trdy))
                  s_next = TX_IDLE;
      default:  s_next = TX_IDLE;
    endcase
  end

  // State-derived outputs; trdy comes only from registered state and count.
  always_comb begin
    s_trdy      = (r_state == TX_RUN) && (r_count < FULL);
    o_busy      = (r_state != TX_IDLE) || s_out_valid;
    o_dbg_state = r_state;
  end

  assign bus.fdi_pl_trdy  = s_trdy;
  assign bus.rdi_lp_data  = s_out_data;
  assign bus.rdi_lp_valid = s_out_valid;

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (s_push) r_mem[r_wr_ptr] <= bus.fdi_lp_data;
  end

  // Pointers and occupancy; simultaneous push and load leave count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (s_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (s_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({s_push, s_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag: a beat offered in RUN while the FIFO is full is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_overflow_detected <= 1'b0;
    else if (bus.fdi_lp_valid && (r_state == TX_RUN) && (r_count == FULL))
      o_overflow_detected <= 1'b1;
  end

  ucie_ctl_tx_out_stage #(.W(W)) u_out_stage (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (s_load),
    .i_load_data (r_mem[r_rd_ptr]),
    .i_pl_trdy   (bus.rdi_pl_trdy),
    .o_data      (s_out_data),
    .o_valid     (s_out_valid)
  );

`ifdef UCIE_CTL_TX_STATS_EN
  // Saturating counters of accepted output beats and backpressured cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tx_beat_count  <= '0;
      o_tx_stall_count <= '0;
    end else begin
      if (s_out_valid && bus.rdi_pl_trdy && (o_tx_beat_count != '1))
        o_tx_beat_count <= o_tx_beat_count + STATS_W'(1);
      if (s_out_valid && !bus.rdi_pl_trdy && (o_tx_stall_count != '1))
        o_tx_stall_count <= o_tx_stall_count + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ucie_ctl_tx_buffer.sv
// Directed bench for ucie_ctl_tx_buffer (NBYTES=8, DEPTH=4). A negedge
// scoreboard tracks every accepted FDI beat in exp_q and checks RDI output
// order; the initial block walks the directed scenarios.
module tb_ucie_ctl_tx_buffer;
  import ucie_ctl_tx_buffer_pkg::*;

  localparam int NB    = 8;
  localparam int DEPTH = 4;
  localparam int W     = NB * 8;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      en  = 1'b0;
  logic      ovf;
  logic      busy;
  tx_state_e st;
`ifdef UCIE_CTL_TX_STATS_EN
  logic [STATS_W-1:0] beat_cnt;
  logic [STATS_W-1:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  ucie_ctl_tx_buffer_if #(.NBYTES(NB)) bus ();

  ucie_ctl_tx_buffer #(.NBYTES(NB), .DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_buffer_en         (en),
    .bus                 (bus),
    .o_overflow_detected (ovf),
    .o_busy              (busy),
    .o_dbg_state         (st)
`ifdef UCIE_CTL_TX_STATS_EN
    ,
    .o_tx_beat_count     (beat_cnt),
    .o_tx_stall_count    (stall_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    bus.fdi_lp_valid = v;
    bus.fdi_lp_data  = d;
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rdi_lp_valid && bus.rdi_pl_trdy) begin
        checks++;
        assert (exp_q.size() != 0)
        else begin
          errors++;
          $error("FAIL sb_unexpected observed=%0h expected=queued_beat", bus.rdi_lp_data);
        end
        if (exp_q.size() != 0) chk("sb_order", bus.rdi_lp_data, exp_q.pop_front());
      end
      if (bus.fdi_lp_valid && bus.fdi_pl_trdy) exp_q.push_back(bus.fdi_lp_data);
    end
  end

  initial begin
    logic [W-1:0] t2_vals[5];
    t2_vals[0] = 64'h11; t2_vals[1] = 64'h22; t2_vals[2] = 64'h33;
    t2_vals[3] = 64'h44; t2_vals[4] = 64'h5A;
    drive(1'b0, '0);
    bus.rdi_pl_trdy = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", bus.rdi_lp_valid, 0);
    chk("rst_data",  bus.rdi_lp_data, 0);
    chk("rst_ovf",   ovf, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_trdy",  bus.fdi_pl_trdy, 0);
    chk("rst_state", st, TX_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic in-order flow, 2-cycle first-word latency, then 1 beat/clock
    en = 1'b1;
    bus.rdi_pl_trdy = 1'b1;
    step();
    chk("t1_state_run", st, TX_RUN);
    chk("t1_trdy", bus.fdi_pl_trdy, 1);
    drive(1'b1, 64'h11); step();
    chk("t1_lat_not_yet", bus.rdi_lp_valid, 0);
    drive(1'b1, 64'h22); step();
    chk("t1_first_valid", bus.rdi_lp_valid, 1);
    chk("t1_data0", bus.rdi_lp_data, 64'h11);
    drive(1'b1, 64'h33); step();
    chk("t1_data1", bus.rdi_lp_data, 64'h22);
    drive(1'b1, 64'h44); step();
    chk("t1_data2", bus.rdi_lp_data, 64'h33);
    drive(1'b0, '0); step();
    chk("t1_data3", bus.rdi_lp_data, 64'h44);
    step();
    chk("t1_idle_out", bus.rdi_lp_valid, 0);
    chk("t1_sb_empty", exp_q.size(), 0);
`ifdef UCIE_CTL_TX_STATS_EN
    chk("t1_beat_cnt", beat_cnt, 4);
    chk("t1_stall_cnt", stall_cnt, 0);
`endif

    // Backpressure: output holds 0x11, FIFO fills (4 entries + output register)
    bus.rdi_pl_trdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, t2_vals[i]);
      step();
      if (i >= 1) chk("t2_hold_data", bus.rdi_lp_data, 64'h11);
    end
    chk("t2_full_trdy", bus.fdi_pl_trdy, 0);
    chk("t2_ovf_clear", ovf, 0);

    // Overflow: 0x55 offered while full must be dropped and flagged
    drive(1'b1, 64'h55); step();
    chk("t3_ovf_set", ovf, 1);
    chk("t3_hold_data", bus.rdi_lp_data, 64'h11);
    drive(1'b0, '0); step();
    chk("t3_ovf_sticky", ovf, 1);
`ifdef UCIE_CTL_TX_STATS_EN
    chk("t3_stall_cnt", stall_cnt, 5);
`endif
    bus.rdi_pl_trdy = 1'b1;
    step();
    chk("t3_next_data", bus.rdi_lp_data, 64'h22);
    for (int k = 0; k < 20 && bus.rdi_lp_valid; k++) step();
    chk("t3_drain_done", bus.rdi_lp_valid, 0);
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_ovf_still", ovf, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t3_ovf_rst", ovf, 0);
    chk("t3_state_rst", st, TX_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Drain on disable: buffered beats still leave, then IDLE
    en = 1'b1;
    bus.rdi_pl_trdy = 1'b0;
    step();
    drive(1'b1, 64'hA1); step();
    drive(1'b1, 64'hA2); step();
    drive(1'b1, 64'hA3); step();
    drive(1'b0, '0);
    en = 1'b0;
    step();
    chk("t4_state_drain", st, TX_DRAIN);
    chk("t4_trdy_off", bus.fdi_pl_trdy, 0);
    chk("t4_busy", busy, 1);
    drive(1'b1, 64'h77); step();
    chk("t4_no_flag", ovf, 0);
    chk("t4_still_drain", st, TX_DRAIN);
    drive(1'b0, '0);
    bus.rdi_pl_trdy = 1'b1;
    for (int k = 0; k < 20 && st != TX_IDLE; k++) step();
    chk("t4_state_idle", st, TX_IDLE);
    chk("t4_busy_off", busy, 0);
    chk("t4_valid_off", bus.rdi_lp_valid, 0);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Full-rate streaming across pointer wrap: occupancy stays at one
    en = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, W'(8'h60 + i));
      step();
      if (i >= 1) begin
        chk("t5_count", dut.r_count, 1);
        chk("t5_trdy", bus.fdi_pl_trdy, 1);
      end
    end
    drive(1'b0, '0);
    for (int k = 0; k < 20 && bus.rdi_lp_valid; k++) step();
    chk("t5_drained", bus.rdi_lp_valid, 0);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-stream discards buffered beats
    bus.rdi_pl_trdy = 1'b0;
    drive(1'b1, 64'hB1); step();
    drive(1'b1, 64'hB2); step();
    drive(1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid_rst", bus.rdi_lp_valid, 0);
    chk("t6_data_rst", bus.rdi_lp_data, 0);
    chk("t6_busy_rst", busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rdi_pl_trdy = 1'b1;
    step();
    drive(1'b1, 64'hAA); step();
    drive(1'b0, '0);
    chk("t6_lat_not_yet", bus.rdi_lp_valid, 0);
    step();
    chk("t6_first_valid", bus.rdi_lp_valid, 1);
    chk("t6_first_data", bus.rdi_lp_data, 64'hAA);
    step();
    chk("t6_done", bus.rdi_lp_valid, 0);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
